// File: rtl/pkt_pkg.sv
// pkt_pkg: shared types, widths and byte math for the 64b-to-32b packet path
package pkt_pkg;
  localparam int LEN_WIDTH = 14;
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        bad;
    logic [2:0]  res;
    logic [63:0] data;
  } pkt_hold_t;
  typedef enum logic {IDLE, IN_PKT} frame_state_t;
  function automatic logic [3:0] res64_to_bytes(input logic [2:0] res);
    return (res == 3'd0) ? 4'd8 : {1'b0, res};
  endfunction
endpackage

// File: rtl/pkt_len_checker.sv
// pkt_len_checker: counts emitted bytes per packet and flags a length mismatch on the eop beat
//   iclk/irst: clock, async active-high reset
//   ilatch/iplen: capture declared length (sop accept)
//   ibeat/isop/ieop/ibytes: one emitted output beat and its byte count
//   omismatch: combinational, high on an eop beat whose total differs from the latched length
module pkt_len_checker
  import pkt_pkg::*;
(
  input  logic                 iclk,
  input  logic                 irst,
  input  logic                 ilatch,
  input  logic [LEN_WIDTH-1:0] iplen,
  input  logic                 ibeat,
  input  logic                 isop,
  input  logic                 ieop,
  input  logic [2:0]           ibytes,
  output logic                 omismatch
);
  logic [LEN_WIDTH-1:0] plen_q, cnt_q, cnt_d;
  logic [LEN_WIDTH:0]   total;
  always_comb begin
    total     = (isop ? '0 : {1'b0, cnt_q}) + {{(LEN_WIDTH-2){1'b0}}, ibytes};
    omismatch = ibeat & ieop & (total != {1'b0, plen_q});
    cnt_d     = !ibeat ? cnt_q : ieop ? '0 : total[LEN_WIDTH] ? '1 : total[LEN_WIDTH-1:0];
  end
  always_ff @(posedge iclk or posedge irst)
    if (irst) begin
      plen_q <= '0;
      cnt_q  <= '0;
    end else begin
      plen_q <= ilatch ? iplen : plen_q;
      cnt_q  <= cnt_d;
    end
endmodule

// File: rtl/packet_downconverter.sv
// packet_downconverter: 64b valid/ready packet stream to 32b stream without backpressure
//   in : iclk, irst, ivalid, isop, ieop, iresidual[2:0], iplen[13:0], idata[63:0], ibad
//   out: iready, ovalid, osop, oeop, oresidual[1:0], odata[31:0], obad, olen_err, oproto_err
module packet_downconverter #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_WIDTH = 14
) (
  input  logic                 iclk,
  input  logic                 irst,
  input  logic                 ivalid,
  output logic                 iready,
  input  logic                 isop,
  input  logic                 ieop,
  input  logic [2:0]           iresidual,
  input  logic [LEN_WIDTH-1:0] iplen,
  input  logic [IN_WIDTH-1:0]  idata,
  input  logic                 ibad,
  output logic                 ovalid,
  output logic                 osop,
  output logic                 oeop,
  output logic [1:0]           oresidual,
  output logic [OUT_WIDTH-1:0] odata,
  output logic                 obad,
  output logic                 olen_err,
  output logic                 oproto_err
);
  import pkt_pkg::*;
  pkt_hold_t    hold_q, hold_d;
  frame_state_t state_q, state_d;
  logic         hv_q, hv_d, half_q, half_d;
  logic         acc, drop, load, proto_d;
  logic [3:0]   b;
  logic         need_lo, emit_sop, emit_eop, mismatch;
  logic [2:0]   beat_bytes;
  assign iready = ~hv_q | half_q;
  always_comb begin
    acc     = ivalid & iready;
    drop    = acc & ~isop & (state_q == IDLE);
    proto_d = drop | (acc & isop & (state_q == IN_PKT));
    load    = acc & ~drop;
    state_d = load ? (ieop ? IDLE : IN_PKT) : state_q;
  end
  // half_q=0 selects the upper half; the lower half is skipped when the eop word fits in 4 bytes
  always_comb begin
    b          = res64_to_bytes(hold_q.res);
    need_lo    = ~hold_q.eop | (b > 4'd4);
    emit_sop   = hv_q & ~half_q & hold_q.sop;
    emit_eop   = hv_q & hold_q.eop & (half_q | ~need_lo);
    beat_bytes = emit_eop ? (half_q ? 3'(b - 4'd4) : b[2:0]) : 3'd4;
    hv_d       = load | (hv_q & ~half_q & need_lo);
    half_d     = ~load & hv_q & ~half_q & need_lo;
    hold_d     = load ? {isop, ieop, ibad, iresidual, idata} : hold_q;
  end
  pkt_len_checker u_len (
    .iclk      (iclk),
    .irst      (irst),
    .ilatch    (load & isop),
    .iplen     (iplen),
    .ibeat     (hv_q),
    .isop      (emit_sop),
    .ieop      (emit_eop),
    .ibytes    (beat_bytes),
    .omismatch (mismatch)
  );
  always_ff @(posedge iclk or posedge irst)
    if (irst) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge iclk or posedge irst)
    if (irst) begin
      hold_q     <= '0;
      hv_q       <= 1'b0;
      half_q     <= 1'b0;
      ovalid     <= 1'b0;
      osop       <= 1'b0;
      oeop       <= 1'b0;
      oresidual  <= 2'd0;
      odata      <= '0;
      obad       <= 1'b0;
      olen_err   <= 1'b0;
      oproto_err <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hv_q       <= hv_d;
      half_q     <= half_d;
      ovalid     <= hv_q;
      osop       <= emit_sop;
      oeop       <= emit_eop;
      oresidual  <= emit_eop ? beat_bytes[1:0] : 2'd0;
      odata      <= !hv_q ? '0 : half_q ? hold_q.data[31:0] : hold_q.data[63:32];
      obad       <= emit_eop & (hold_q.bad | mismatch);
      olen_err   <= mismatch;
      oproto_err <= proto_d;
    end
endmodule

// File: tb/tb_packet_downconverter.sv
// tb_packet_downconverter: randomized self-checking bench with a byte-stream reference model
module tb_packet_downconverter;
  logic        iclk = 0, irst = 1, ivalid = 0, isop = 0, ieop = 0, ibad = 0;
  logic [2:0]  iresidual = 0;
  logic [13:0] iplen = 0;
  logic [63:0] idata = 0;
  logic        iready, ovalid, osop, oeop, obad, olen_err, oproto_err;
  logic [1:0]  oresidual;
  logic [31:0] odata;

  always #5 iclk = ~iclk;

  packet_downconverter dut (
    .iclk(iclk), .irst(irst), .ivalid(ivalid), .iready(iready), .isop(isop), .ieop(ieop),
    .iresidual(iresidual), .iplen(iplen), .idata(idata), .ibad(ibad), .ovalid(ovalid),
    .osop(osop), .oeop(oeop), .oresidual(oresidual), .odata(odata), .obad(obad),
    .olen_err(olen_err), .oproto_err(oproto_err)
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  res;
    logic [31:0] data;
    logic        bad;
    logic        lerr;
  } beat_t;

  beat_t exp_q[$], obs_q[$];
  logic  rdy_q[$];
  logic  rec_rdy = 0;
  int    total = 0, bad = 0, proto_cnt = 0, stray = 0, run = 0, max_run = 0;

  always @(negedge iclk) begin
    if (ovalid) obs_q.push_back('{osop, oeop, oresidual, odata, obad, olen_err});
    if (oproto_err) proto_cnt++;
    if (olen_err && !(ovalid && oeop && obad)) stray++;
    run = ovalid ? run + 1 : 0;
    if (run > max_run) max_run = run;
  end

  task automatic drive_word(input logic s, input logic e, input logic bd, input logic [2:0] r,
                            input logic [13:0] pl, input logic [63:0] d);
    int n = 0;
    ivalid = 1; isop = s; ieop = e; ibad = bd; iresidual = r; iplen = pl; idata = d;
    if (rec_rdy) rdy_q.push_back(iready);
    while (!iready && n < 20) begin
      @(posedge iclk); #1;
      n++;
      if (rec_rdy) rdy_q.push_back(iready);
    end
    if (!iready) begin
      total++; bad++;
      $display("FAIL drive_timeout iready=%b required=1", iready);
    end
    @(posedge iclk); #1;
    ivalid = 0; isop = 0; ieop = 0; ibad = 0;
  endtask

  // Model: the packet is a byte stream of 32-bit halves; output beats are consecutive 4-byte chunks.
  task automatic send_pkt(input int n, input int b, input int plen, input logic bd,
                          input int gap, input logic close);
    logic [63:0] w[$];
    logic [31:0] halves[$];
    int          nbytes, nb;
    logic        mism, last;
    for (int i = 0; i < n; i++) begin
      w.push_back({$urandom, $urandom});
      halves.push_back(w[i][63:32]);
      halves.push_back(w[i][31:0]);
    end
    nbytes = close ? 8 * (n - 1) + b : 8 * n;
    nb     = (nbytes + 3) / 4;
    mism   = close && (nbytes != plen);
    for (int k = 0; k < nb; k++) begin
      last = close && (k == nb - 1);
      exp_q.push_back('{k == 0, last, last ? 2'(nbytes % 4) : 2'd0, halves[k],
                        last && (bd || mism), last && mism});
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, gap)) begin @(posedge iclk); #1; end
      drive_word(i == 0, close && i == n - 1, i == n - 1 ? bd : 1'($urandom),
                 i == n - 1 ? 3'(b % 8) : 3'($urandom), i == 0 ? 14'(plen) : 14'($urandom), w[i]);
    end
  endtask

  task automatic check_stream(input string name);
    repeat (8) @(posedge iclk);
    #1;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s beat_count got=%0d exp=%0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (obs_q[k] !== exp_q[k]) begin
          bad++;
          $display("FAIL %s beat%0d got=%h exp=%h", name, k, obs_q[k], exp_q[k]);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge iclk);
    #1;
    total++;
    if ({ovalid, osop, oeop, oresidual, odata, obad, olen_err, oproto_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {ovalid, osop, oeop, oresidual, odata, obad, olen_err, oproto_err});
    end
    irst = 0;
    #1;
    total++;
    if (iready !== 1'b1) begin bad++; $display("FAIL reset_iready got=%b exp=1", iready); end
  endtask

  task automatic test_single_word();
    send_pkt(1, 8, 8, 0, 0, 1);
    check_stream("single_word");
  endtask

  task automatic test_two_words();
    send_pkt(2, 5, 13, 0, 0, 1);
    check_stream("two_words");
  endtask

  task automatic test_short();
    logic [63:0] d;
    d = {$urandom, $urandom};
    exp_q.push_back('{1'b1, 1'b1, 2'd3, d[63:32], 1'b0, 1'b0});
    drive_word(1, 1, 0, 3'd3, 14'd3, d);
    total++;
    if (ovalid !== 1'b0) begin bad++; $display("FAIL short_latency_n1 ovalid got=%b exp=0", ovalid); end
    @(posedge iclk); #1;
    total++;
    if ({ovalid, osop, oeop, oresidual, odata} !== {3'b111, 2'd3, d[63:32]}) begin
      bad++;
      $display("FAIL short_beat got=%h exp=%h", {ovalid, osop, oeop, oresidual, odata}, {3'b111, 2'd3, d[63:32]});
    end
    check_stream("short");
  endtask

  task automatic test_len_err();
    int s0;
    s0 = stray;
    send_pkt(2, 8, 20, 0, 0, 1);
    check_stream("len_err");
    total++;
    if (stray != s0) begin bad++; $display("FAIL len_err_stray got=%0d exp=0", stray - s0); end
  endtask

  task automatic test_back_to_back();
    int b;
    rdy_q.delete();
    max_run = 0;
    rec_rdy = 1;
    for (int p = 0; p < 3; p++) begin
      b = $urandom_range(5, 8);
      send_pkt(3, b, 16 + b, 0, 0, 1);
    end
    rec_rdy = 0;
    check_stream("back_to_back");
    total++;
    if (rdy_q.size() != 17) begin
      bad++;
      $display("FAIL b2b_ready_len got=%0d exp=17", rdy_q.size());
    end else begin
      for (int k = 0; k < 17; k++) begin
        total++;
        if (rdy_q[k] !== (k % 2 == 0)) begin
          bad++;
          $display("FAIL b2b_ready%0d got=%b exp=%b", k, rdy_q[k], k % 2 == 0);
        end
      end
    end
    total++;
    if (max_run != 18) begin bad++; $display("FAIL b2b_ovalid_run got=%0d exp=18", max_run); end
  endtask

  task automatic test_framing();
    int p0;
    p0 = proto_cnt;
    send_pkt(1, 8, 8, 0, 0, 0);
    send_pkt(1, 8, 8, 0, 0, 1);
    drive_word(0, 1, 0, 3'd0, 14'd8, {$urandom, $urandom});
    check_stream("framing");
    total++;
    if (proto_cnt - p0 != 2) begin bad++; $display("FAIL framing_proto got=%0d exp=2", proto_cnt - p0); end
  endtask

  task automatic test_reset_mid();
    int p0;
    drive_word(1, 0, 0, 3'd0, 14'd32, {$urandom, $urandom});
    drive_word(0, 0, 0, 3'd0, 14'd0, {$urandom, $urandom});
    @(posedge iclk); #3;
    irst = 1;
    #1;
    total++;
    if ({ovalid, osop, oeop, odata, obad} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs got=%h exp=0", {ovalid, osop, oeop, odata, obad});
    end
    total++;
    if (iready !== 1'b1) begin bad++; $display("FAIL rst_mid_iready got=%b exp=1", iready); end
    @(posedge iclk); #1;
    irst = 0;
    obs_q.delete();
    exp_q.delete();
    p0 = proto_cnt;
    drive_word(0, 1, 0, 3'd0, 14'd8, {$urandom, $urandom});
    send_pkt(2, 6, 14, 0, 1, 1);
    check_stream("rst_mid");
    total++;
    if (proto_cnt - p0 != 1) begin bad++; $display("FAIL rst_mid_proto got=%0d exp=1", proto_cnt - p0); end
  endtask

  task automatic test_random();
    int n, b, len, s0, p0;
    s0 = stray;
    p0 = proto_cnt;
    for (int p = 0; p < 25; p++) begin
      n   = $urandom_range(1, 4);
      b   = $urandom_range(1, 8);
      len = 8 * (n - 1) + b;
      send_pkt(n, b, $urandom_range(0, 1) ? len : $urandom_range(0, 40), ($urandom_range(0, 3) == 0), 2, 1);
    end
    check_stream("random");
    total++;
    if (stray != s0) begin bad++; $display("FAIL random_stray got=%0d exp=0", stray - s0); end
    total++;
    if (proto_cnt != p0) begin bad++; $display("FAIL random_proto got=%0d exp=0", proto_cnt - p0); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_short();
    test_len_err();
    test_back_to_back();
    test_framing();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
